// File: rtl/line_data_memory_pkg.sv
// Shared definitions for the line-wide backing memory and the data cache above it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package line_data_memory_pkg;

    // Line geometry, shared with the cache.
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    // Access-latency counter width; LATENCY is capped at 255 so it never wraps.
    localparam int CNT_W    = 8;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_data_memory_ram.sv
// DEPTH x 256-bit synchronous single-port line storage with a registered read port.
// Latency: write lands at the strobed edge; read data is registered at the strobed edge.
// Backpressure: none; the controller strobes at most one access per request.
//
// Ports: clk_i/rst_i clock and async active-low reset (read register only),
//        we_i/re_i write/read strobes, idx_i line index, wdata_i write line,
//        rdata_o last line read (holds until the next read strobe).
module dmem_line_ram
    import line_data_memory_pkg::*;
#(
    parameter  int DEPTH = 512,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    line_t mem_q [DEPTH];
    line_t rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register doubles as the memory's data output, so it only moves on a read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_data_memory.sv
// Line-wide backing data memory below the data cache: one 256-bit read or write per request.
// Latency: ack_o pulses LATENCY+1 cycles after the cycle a request is accepted.
// Backpressure: enable_i must be held until ack_o; requests are only accepted in IDLE.
//
// Ports: clk_i/rst_i clock and async active-low reset; enable_i/write_i/addr_i/data_i
//        request (sampled at acceptance only); ack_o one-cycle completion pulse;
//        data_o read line (held until next read); busy_o high while a request is in flight.
module line_data_memory
    import line_data_memory_pkg::*;
#(
    parameter  int LATENCY = 10,
    parameter  int DEPTH   = 512,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    line_t              wdat_q;
    logic               accept;
    logic               access;

    // Offset and above-range address bits are dropped; high bits alias by truncation.
    logic [IDX_W-1:0]   addr_idx;
    logic               unused_addr;
    assign addr_idx    = addr_i[OFFSET_W +: IDX_W];
    assign unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        ack_o   = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    access  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // enable_i is ignored here so a master still holding it high
                // is not re-accepted on the same edge it samples the ack.
                busy_o  = 1'b1;
                ack_o   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch: only the values present at acceptance are used.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q   <= 1'b0;
            idx_q  <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            wr_q   <= write_i;
            idx_q  <= addr_idx;
            wdat_q <= data_i;
        end
    end

    dmem_line_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (access & wr_q),
        .re_i    (access & ~wr_q),
        .idx_i   (idx_q),
        .wdata_i (wdat_q),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_line_data_memory.sv
// Bench for line_data_memory: one instance at LATENCY=10, one at LATENCY=1.
// Every ack pops the scoreboard and compares data_o; tasks check latency and idle/busy.
module tb_line_data_memory;

    localparam int DEPTH = 512;
    localparam int LAT0  = 10;
    localparam int LAT1  = 1;

    logic         clk;
    logic         rst_n;
    logic         en    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] wdat  [2];
    logic         ack   [2];
    logic [255:0] dout  [2];
    logic         busy  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model and expected data_o per instance.
    logic [255:0] m0 [int];
    logic [255:0] m1 [int];
    logic [255:0] last0, last1;
    logic [255:0] q0 [$];
    logic [255:0] q1 [$];

    line_data_memory #(.LATENCY(LAT0), .DEPTH(DEPTH)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en[0]), .write_i(wr[0]), .addr_i(addr[0]),
        .data_i(wdat[0]), .ack_o(ack[0]), .data_o(dout[0]), .busy_o(busy[0])
    );

    line_data_memory #(.LATENCY(LAT1), .DEPTH(DEPTH)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en[1]), .write_i(wr[1]), .addr_i(addr[1]),
        .data_i(wdat[1]), .ack_o(ack[1]), .data_o(dout[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int line_idx(input logic [31:0] a);
        return int'((a >> 5) & 32'(DEPTH - 1));
    endfunction

    // Expected data_o at each ack: the line for a read, the previous read value for a write.
    function automatic void sb_push(input int s, input bit w, input logic [31:0] a,
                                    input logic [255:0] d);
        int i;
        i = line_idx(a);
        if (s == 0) begin
            if (w) m0[i] = d;
            else   last0 = m0.exists(i) ? m0[i] : '0;
            q0.push_back(last0);
        end else begin
            if (w) m1[i] = d;
            else   last1 = m1.exists(i) ? m1[i] : '0;
            q1.push_back(last1);
        end
    endfunction

    always @(negedge clk) begin
        logic [255:0] e;
        if (rst_n && ack[0]) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL ack0_unexpected: ack_o=1 with no request outstanding");
            end else begin
                e = q0.pop_front();
                if (dout[0] !== e) begin
                    n_fail++;
                    $display("FAIL data0: data_o=%h expected %h", dout[0], e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] e;
        if (rst_n && ack[1]) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL ack1_unexpected: ack_o=1 with no request outstanding");
            end else begin
                e = q1.pop_front();
                if (dout[1] !== e) begin
                    n_fail++;
                    $display("FAIL data1: data_o=%h expected %h", dout[1], e);
                end
            end
        end
    end

    // Issue one request starting in the current cycle; lat = cycles to ack (-1 on timeout).
    // keep: hold enable_i and switch to a read of na at the ack edge.
    task automatic req(input int s, input bit w, input logic [31:0] a, input logic [255:0] d,
                       input bit keep, input logic [31:0] na,
                       output int lat, output logic busy1, output logic ack_after);
        sb_push(s, w, a, d);
        en[s] = 1'b1; wr[s] = w; addr[s] = a; wdat[s] = d;
        lat = -1;
        busy1 = 1'bx;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 1) busy1 = busy[s];
            if (ack[s]) begin
                lat = k;
                break;
            end
        end
        if (keep) begin
            wr[s] = 1'b0; addr[s] = na; wdat[s] = '1;
        end else begin
            en[s] = 1'b0;
        end
        @(posedge clk); #1;
        ack_after = ack[s];
    endtask

    task automatic check_idle(input string name, input int s, input logic [255:0] exp_d);
        n_checks++;
        if (ack[s] !== 1'b0 || busy[s] !== 1'b0 || dout[s] !== exp_d) begin
            n_fail++;
            $display("FAIL %s: ack=%b busy=%b data_o=%h, required ack=0 busy=0 data_o=%h",
                     name, ack[s], busy[s], dout[s], exp_d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            en[s] = 0; wr[s] = 0; addr[s] = 0; wdat[s] = 0;
        end
        last0 = '0; last1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_dut0", 0, '0);
        check_idle("reset_dut1", 1, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("post_reset_dut0", 0, '0);
        check_idle("post_reset_dut1", 1, '0);
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic b1, aa;
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        req(0, 1'b1, 32'h0000_0400, a5, 1'b0, 32'h0, lat, b1, aa);
        // Pending write that must be dropped.
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0400; wdat[0] = {8{32'hFFFF_0000}};
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_wait: busy=%b required 1", busy[0]);
        end
        rst_n = 1'b0;
        en[0] = 1'b0; wr[0] = 1'b0;
        #1;
        check_idle("async_reset_immediate", 0, '0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_idle("reset_mid_wait", 0, '0);
        end
        rst_n = 1'b1;
        last0 = '0; last1 = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check_idle("idle_after_reset", 0, '0);
        end
    endtask

    task automatic test_read_latency();
        int lat; logic b1, aa;
        req(0, 1'b0, 32'h0000_0400, '0, 1'b0, 32'h0, lat, b1, aa);
        n_checks++;
        if (lat !== LAT0 + 1 || b1 !== 1'b1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency: lat=%0d busy1=%b ack_after=%b, required lat=%0d busy1=1 ack_after=0",
                     lat, b1, aa, LAT0 + 1);
        end
        n_checks++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_ack: busy=%b required 0", busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat_w, lat_r; logic b1, aa;
        logic [255:0] d;
        d = {32'h1234_5678, {6{32'h0BAD_F00D}}, 32'h0000_DEAD};
        req(0, 1'b1, 32'h0000_0020, d, 1'b1, 32'h0000_0020, lat_w, b1, aa);
        n_checks++;
        if (lat_w !== LAT0 + 1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_write: lat=%0d ack_after=%b, required lat=%0d ack_after=0",
                     lat_w, aa, LAT0 + 1);
        end
        // enable_i stays high: the read is visible in the IDLE cycle right after the ack.
        req(0, 1'b0, 32'h0000_0020, '0, 1'b0, 32'h0, lat_r, b1, aa);
        n_checks++;
        if (lat_r !== LAT0 + 1) begin
            n_fail++;
            $display("FAIL b2b_read: lat=%0d required %0d", lat_r, LAT0 + 1);
        end
    endtask

    task automatic test_input_churn();
        int lat; logic b1, aa;
        req(0, 1'b1, 32'h0000_0040, {8{32'h2222_2222}}, 1'b0, 32'h0, lat, b1, aa);
        req(0, 1'b1, 32'h0000_0080, {8{32'h4444_4444}}, 1'b0, 32'h0, lat, b1, aa);
        sb_push(0, 1'b0, 32'h0000_0040, '0);
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0040; wdat[0] = '0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                addr[0] = 32'h0000_0080; wr[0] = 1'b1; wdat[0] = {8{32'hDEAD_BEEF}};
            end
            if (ack[0]) begin
                lat = k;
                break;
            end
        end
        en[0] = 1'b0; wr[0] = 1'b0;
        n_checks++;
        if (lat !== LAT0 + 1) begin
            n_fail++;
            $display("FAIL churn_latency: lat=%0d required %0d", lat, LAT0 + 1);
        end
        @(posedge clk); #1;
        req(0, 1'b0, 32'h0000_0080, '0, 1'b0, 32'h0, lat, b1, aa);
        n_checks++;
        if (lat !== LAT0 + 1) begin
            n_fail++;
            $display("FAIL churn_readback: lat=%0d required %0d", lat, LAT0 + 1);
        end
    endtask

    task automatic test_alias_lat1();
        int lat; logic b1, aa;
        req(1, 1'b1, 32'h8000_0060, {4{64'h0123_4567_89AB_CDEF}}, 1'b0, 32'h0, lat, b1, aa);
        n_checks++;
        if (lat !== LAT1 + 1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_write: lat=%0d ack_after=%b, required lat=%0d ack_after=0",
                     lat, aa, LAT1 + 1);
        end
        req(1, 1'b0, 32'h0000_0060, '0, 1'b0, 32'h0, lat, b1, aa);
        n_checks++;
        if (lat !== LAT1 + 1 || b1 !== 1'b1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_read: lat=%0d busy1=%b ack_after=%b, required lat=%0d busy1=1 ack_after=0",
                     lat, b1, aa, LAT1 + 1);
        end
    endtask

    task automatic test_offset();
        int lat; logic b1, aa;
        req(1, 1'b0, 32'h0000_007C, '0, 1'b0, 32'h0, lat, b1, aa);
        n_checks++;
        if (lat !== LAT1 + 1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL offset_read: lat=%0d ack_after=%b, required lat=%0d ack_after=0",
                     lat, aa, LAT1 + 1);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: outstanding q0=%0d q1=%0d required 0 0",
                     q0.size(), q1.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_read_latency();
        test_back_to_back();
        test_input_churn();
        test_alias_lat1();
        test_offset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_data_memory.md
# line_data_memory

Line-wide backing data memory directly downstream of the data cache. Accepts one 256-bit line read or write per request over an enable/ack handshake, models a fixed multi-cycle access latency, and returns read data alongside a one-cycle ack pulse. It is the sole target of the cache's miss-fill and dirty write-back traffic.

## Interface
- LATENCY, 10, wait cycles between request acceptance and ack; legal range 1..255.
- DEPTH, 512, number of 256-bit lines; power of two.
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  request valid; held high by the master until it samples ack_o.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  32  byte address; bits [4:0] ignored; line index = addr_i[5+log2(DEPTH)-1:5]; upper bits ignored.
- data_i  in  256  write line data; sampled with enable_i.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line data; valid while ack_o is high, held until the next read completes.
- busy_o  out  1  high in WAIT and ACK.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: at a rising edge with enable_i=1, latch write_i, line index and data_i, clear the counter, go to WAIT. With enable_i=0, stay in IDLE.
- WAIT: counter increments each edge. At the edge where counter == LATENCY-1, go to ACK and perform the access on the latched request:
  - Write: store the latched data into the line.
  - Read: load the line into the data_o register.
- ACK: ack_o=1 for exactly one cycle. The next edge returns to IDLE unconditionally, and enable_i is ignored at that edge.
- Input changes during WAIT/ACK are ignored; only the values latched at acceptance matter.
- A write does not modify data_o.
- Read-after-write to the same line returns the written data.
- Counter width is 8 bits. It never wraps, because LATENCY is at most 255.
- Out-of-range upper address bits alias by truncation; they are not an error.

## Timing
- Request first visible in IDLE cycle c: ack_o high in cycle c+LATENCY+1 and low in c+LATENCY+2.
- Minimum gap between back-to-back requests:
  - After ack in cycle a, the next request can be accepted at the end of cycle a+1 at the earliest (IDLE cycle).
  - This matches a master that clears enable_i, or changes write_i/addr_i, at the edge where it samples ack_o high.
- Reset (asynchronous, any state including mid-WAIT):
  - State returns to IDLE, counter 0, ack_o 0, busy_o 0, data_o 0.
  - An in-flight write is dropped and the memory line is not modified.
  - Memory contents are not reset. The bench preloads them.
- busy_o goes high the cycle after acceptance and low the cycle after ack.

## Structure
- Shared package holds:
  - LINE_W=256 and OFFSET_W=5, also used by the cache.
  - The state enum (IDLE/WAIT/ACK).
  - A line typedef.
- Storage lives in one sub-module, dmem_line_ram:
  - Synchronous single-port array of DEPTH x 256.
  - Ports: write enable, index, wdata, registered rdata.
- The FSM, counter and request latch stay in the top.

## Test plan
- Reset then idle: rst_i low 3 cycles mid-WAIT of a pending write to 0x0000_0400 -> ack_o never pulses, line 0x0000_0400 unchanged, data_o=0, busy_o=0.
- Read latency: preload line 32 (addr 0x0000_0400) with 0xA5..A5; request read with LATENCY=10 in cycle 5 -> ack_o high exactly in cycle 16, data_o=0xA5..A5, ack_o low in cycle 17.
- Write then read, back to back: write 0x1234..DEAD to 0x0000_0020, clear write_i and keep enable_i at ack -> read accepted in the following IDLE cycle, data_o=0x1234..DEAD.
- Input churn: during WAIT of a read to 0x40, toggle addr_i to 0x80 and write_i to 1 -> read of line 2 returned, line 4 unmodified.
- Aliasing and LATENCY=1: write to 0x8000_0060 with DEPTH=512, then read 0x0000_0060 -> same data returned; each ack occurs 2 cycles after request.
- Offset ignored: read 0x0000_007C -> returns line 3 (0x60), ack a single cycle.
